// File: rtl/fp_flt.sv
// IEEE-754 single-precision "less than" comparator: y = (x1 < x2).
// Subnormals compare exactly, signed zeros are equal, and any NaN operand gives 0.
module fp_flt #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    output logic        y
);

    // Sign-magnitude ordering. Equal magnitudes fall out as 0 through the strict compares.
    function automatic logic flt_cmp(input logic [31:0] a, input logic [31:0] b);
        logic a_nan;
        logic b_nan;
        logic res;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        if (a_nan || b_nan) begin
            res = 1'b0;
        end else if ((a[30:0] == 31'h0) && (b[30:0] == 31'h0)) begin
            res = 1'b0;
        end else if (a[31] != b[31]) begin
            res = a[31];
        end else if (a[31] == 1'b0) begin
            res = (a[30:0] < b[30:0]);
        end else begin
            res = (a[30:0] > b[30:0]);
        end
        return res;
    endfunction

    logic cmp_s;

    // Combinational compare of the current operand pair
    always_comb begin
        cmp_s = flt_cmp(x1, x2);
    end

    if (OUT_REG) begin : g_reg
        logic valid_d, valid_q;
        logic y_d, y_q;

        // Next-state for the output register; y holds while no pair is offered
        always_comb begin
            valid_d = 1'b0;
            y_d     = y_q;
            if (in_valid) begin
                valid_d = 1'b1;
                y_d     = cmp_s;
            end else begin
                valid_d = 1'b0;
                y_d     = y_q;
            end
        end

        // Output register with synchronous reset taking priority over in_valid
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                y_q     <= 1'b0;
            end else begin
                valid_q <= valid_d;
                y_q     <= y_d;
            end
        end

        assign out_valid = valid_q;
        assign y         = y_q;
    end else begin : g_comb
        assign out_valid = in_valid & ~rst;
        assign y         = rst ? 1'b0 : cmp_s;
    end

endmodule

// File: tb/tb_fp_flt.sv
// Directed and swept checks of fp_flt (registered configuration) against an
// ordered-key reference model of IEEE-754 single "less than".
module tb_fp_flt;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        y;

    int vectors     = 0;
    int miscompares = 0;

    fp_flt #(.OUT_REG(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .x1       (x1),
        .x2       (x2),
        .out_valid(out_valid),
        .y        (y)
    );

    always #5 clk = ~clk;

    // Map a float onto an unsigned key whose natural order is numeric order.
    function automatic logic [31:0] order_key(input logic [31:0] v);
        if (v[30:0] == 31'h0)      return 32'h8000_0000;
        else if (v[31] == 1'b1)    return ~v;
        else                       return v | 32'h8000_0000;
    endfunction

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) ||
            (b[30:23] == 8'hFF && b[22:0] != 23'h0)) return 1'b0;
        return order_key(a) < order_key(b);
    endfunction

    // Present one pair, let one rising edge pass, then compare just after it.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_valid, input logic exp_y);
        rst      = r;
        in_valid = v;
        x1       = a;
        x2       = b;
        @(posedge clk);
        #1;
        vectors++;
        assert (out_valid === exp_valid && y === exp_y) else begin
            miscompares++;
            $error("FAIL %s: x1=%h x2=%h observed valid=%b y=%b expected valid=%b y=%b",
                   tag, a, b, out_valid, y, exp_valid, exp_y);
        end
    endtask

    logic [31:0] pool[$];
    logic [22:0] fracs[8];

    initial begin
        rst = 1'b1; in_valid = 1'b0; x1 = 32'h0; x2 = 32'h0;
        @(posedge clk); #1;

        // Reset wins over in_valid; pairs offered during reset are dropped
        step("rst0", 1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        step("post_rst", 1'b0, 1'b1, 32'h3F800000, 32'h40000000, 1'b1, 1'b1);
        step("hold1", 1'b0, 1'b0, 32'h40000000, 32'h3F800000, 1'b0, 1'b1);
        step("res0", 1'b0, 1'b1, 32'h40000000, 32'h3F800000, 1'b1, 1'b0);
        step("hold0", 1'b0, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);

        // Sign and zero handling
        step("neg_pos", 1'b0, 1'b1, 32'hBF800000, 32'h3F800000, 1'b1, 1'b1);
        step("pos_neg", 1'b0, 1'b1, 32'h3F800000, 32'hBF800000, 1'b1, 1'b0);
        step("mz_pz",   1'b0, 1'b1, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
        step("pz_mz",   1'b0, 1'b1, 32'h00000000, 32'h80000000, 1'b1, 1'b0);

        // Same exponent negatives, equal patterns
        step("neg_mag", 1'b0, 1'b1, 32'hC0000000, 32'hBFFFFFFF, 1'b1, 1'b1);
        step("neg_mag2",1'b0, 1'b1, 32'hBFFFFFFF, 32'hC0000000, 1'b1, 1'b0);
        step("equal",   1'b0, 1'b1, 32'h40000000, 32'h40000000, 1'b1, 1'b0);

        // Subnormals
        step("sub1",    1'b0, 1'b1, 32'h00000001, 32'h00000002, 1'b1, 1'b1);
        step("sub2",    1'b0, 1'b1, 32'h807FFFFF, 32'h80000001, 1'b1, 1'b1);
        step("sub_nrm", 1'b0, 1'b1, 32'h00000001, 32'h00800000, 1'b1, 1'b1);
        step("nsub_z",  1'b0, 1'b1, 32'h80000001, 32'h00000000, 1'b1, 1'b1);

        // Infinities and NaN
        step("max_inf", 1'b0, 1'b1, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b1);
        step("ninf",    1'b0, 1'b1, 32'hFF800000, 32'hFF7FFFFF, 1'b1, 1'b1);
        step("nan_a",   1'b0, 1'b1, 32'h7FC00000, 32'h3F800000, 1'b1, 1'b0);
        step("nan_b",   1'b0, 1'b1, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0);
        step("snan_ninf",1'b0,1'b1, 32'hFF800001, 32'hFF800000, 1'b1, 1'b0);

        // Sweep pool: every finite exponent x sign x edge fractions, back-to-back pairs
        fracs[0] = 23'h000000; fracs[1] = 23'h000001; fracs[2] = 23'h000002;
        fracs[3] = 23'h380000; fracs[4] = 23'h400000; fracs[5] = 23'h2FFFFF;
        fracs[6] = 23'h7FFFFF; fracs[7] = 23'h000000;
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 255; e++) begin
                for (int f = 0; f < 8; f++) begin
                    logic [22:0] fr;
                    logic [7:0]  ex;
                    fr = (f == 7) ? 23'($urandom) : fracs[f];
                    ex = 8'(e);
                    pool.push_back({s[0], ex, fr});
                end
            end
        end
        for (int i = 0; i < pool.size(); i++) begin
            int j;
            j = (i * 37 + 11) % pool.size();
            step("sweep_a", 1'b0, 1'b1, pool[i], pool[j], 1'b1, ref_lt(pool[i], pool[j]));
            j = $urandom_range(pool.size() - 1, 0);
            step("sweep_b", 1'b0, 1'b1, pool[j], pool[i], 1'b1, ref_lt(pool[j], pool[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
